// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the 16-entry register file: round-robin ALU/load
// grant, registered write port, per-register pending scoreboard and hazards.
//
// Ports:
//   clk, reset (async, active-low), start (sync clear)
//   a_valid/a_ready/a_dest/a_data  ALU write-back request
//   b_valid/b_ready/b_dest/b_data  load-unit write-back request
//   rsv_en/rsv_dest                destination reservation from issue
//   chk_reg1/chk_reg2 -> hazard1/hazard2  decode source checks
//   rf_write_en/rf_reg_dest/rf_val_in     register file write port
//   pending                        scoreboard, one bit per register
//   waw_err                        sticky double-reservation flag
module reg_wb_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_dest,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_dest,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_dest,
  input  logic [ADDR_W-1:0]   chk_reg1,
  input  logic [ADDR_W-1:0]   chk_reg2,
  output logic                hazard1,
  output logic                hazard2,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_reg_dest,
  output logic [DATA_W-1:0]   rf_val_in,
  output logic [NUM_REGS-1:0] pending,
  output logic                waw_err
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e                r_ptr;
  ptr_e                w_ptr_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_dest;
  logic [DATA_W-1:0]   r_val;
  logic [NUM_REGS-1:0] r_pend;
  logic                r_waw;

  logic                w_both;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_xdest;
  logic [DATA_W-1:0]   w_xdata;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_dest_nxt;
  logic [DATA_W-1:0]   w_val_nxt;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic                w_waw_nxt;
  logic                w_rsv_hit;

  // Out-of-range indices (NUM_REGS < 2**ADDR_W) read as not pending.
  function automatic logic f_bit(
    input logic [NUM_REGS-1:0] v,
    input logic [ADDR_W-1:0]   idx
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == ADDR_W'(i)) r = v[i];
    end
    return r;
  endfunction

  // Grants: start blocks both sides for the whole cycle.
  always_comb begin
    w_both    = a_valid && b_valid;
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!start) begin
      if (w_both) begin
        w_grant_a = (r_ptr == PTR_A);
        w_grant_b = (r_ptr == PTR_B);
      end else begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
      end
    end
  end

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;
  assign w_xfer  = w_grant_a || w_grant_b;
  assign w_xdest = w_grant_a ? a_dest : b_dest;
  assign w_xdata = w_grant_a ? a_data : b_data;

  // Pointer moves to the loser only on a contested grant.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (start) begin
      w_ptr_nxt = PTR_A;
    end else if (w_both) begin
      w_ptr_nxt = w_grant_a ? PTR_B : PTR_A;
    end
  end

  // Write port: pulse for one cycle per transfer, hold dest/val otherwise.
  always_comb begin
    w_we_nxt   = 1'b0;
    w_dest_nxt = r_dest;
    w_val_nxt  = r_val;
    if (w_xfer) begin
      w_we_nxt   = 1'b1;
      w_dest_nxt = w_xdest;
      w_val_nxt  = w_xdata;
    end
  end

  // Scoreboard: a reservation beats a same-edge clear of that register.
  always_comb begin
    w_pend_nxt = r_pend;
    w_rsv_hit  = rsv_en && !start && f_bit(r_pend, rsv_dest);
    w_waw_nxt  = r_waw || w_rsv_hit;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_xfer && (w_xdest == ADDR_W'(i))) w_pend_nxt[i] = 1'b0;
      if (rsv_en && !start && (rsv_dest == ADDR_W'(i)))
        w_pend_nxt[i] = 1'b1;
    end
    if (start) begin
      w_pend_nxt = '0;
      w_waw_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr  <= PTR_A;
      r_we   <= 1'b0;
      r_dest <= '0;
      r_val  <= '0;
      r_pend <= '0;
      r_waw  <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_we   <= w_we_nxt;
      r_dest <= w_dest_nxt;
      r_val  <= w_val_nxt;
      r_pend <= w_pend_nxt;
      r_waw  <= w_waw_nxt;
    end
  end

  assign rf_write_en = r_we;
  assign rf_reg_dest = r_dest;
  assign rf_val_in   = r_val;
  assign pending     = r_pend;
  assign waw_err     = r_waw;

  // The register file's read data is registered on the commit edge, so a
  // register being written this cycle still reads stale and must stall.
  assign hazard1 = f_bit(r_pend, chk_reg1)
                || (r_we && (r_dest == chk_reg1));
  assign hazard2 = f_bit(r_pend, chk_reg2)
                || (r_we && (r_dest == chk_reg2));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: vector table plus hand sequences
// for double reservation and asynchronous reset mid-write.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_dest;
  logic [7:0]  a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_dest;
  logic [7:0]  b_data;
  logic        rsv_en;
  logic [3:0]  rsv_dest;
  logic [3:0]  chk_reg1;
  logic [3:0]  chk_reg2;
  logic        hazard1;
  logic        hazard2;
  logic        rf_write_en;
  logic [3:0]  rf_reg_dest;
  logic [7:0]  rf_val_in;
  logic [15:0] pending;
  logic        waw_err;

  int n_checks = 0;
  int n_errors = 0;

  reg_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_dest     (a_dest),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_dest     (b_dest),
    .b_data     (b_data),
    .rsv_en     (rsv_en),
    .rsv_dest   (rsv_dest),
    .chk_reg1   (chk_reg1),
    .chk_reg2   (chk_reg2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .rf_write_en(rf_write_en),
    .rf_reg_dest(rf_reg_dest),
    .rf_val_in  (rf_val_in),
    .pending    (pending),
    .waw_err    (waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        av;
    logic [3:0]  ad;
    logic [7:0]  adat;
    logic        bv;
    logic [3:0]  bd;
    logic [7:0]  bdat;
    logic        rv;
    logic [3:0]  rd;
    logic [3:0]  c1;
    logic [3:0]  c2;
    logic        ear;
    logic        ebr;
    logic        eh1;
    logic        eh2;
    logic        ewe;
    logic [3:0]  edst;
    logic [7:0]  eval;
    logic [15:0] epend;
    logic        ewaw;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  function automatic vec_t mk(
    input logic st, av, input logic [3:0] ad, input logic [7:0] adat,
    input logic bv, input logic [3:0] bd, input logic [7:0] bdat,
    input logic rv, input logic [3:0] rd,
    input logic [3:0] c1, c2,
    input logic ear, ebr, eh1, eh2, ewe,
    input logic [3:0] edst, input logic [7:0] eval,
    input logic [15:0] epend, input logic ewaw
  );
    vec_t v;
    v.st = st; v.av = av; v.ad = ad; v.adat = adat;
    v.bv = bv; v.bd = bd; v.bdat = bdat;
    v.rv = rv; v.rd = rd; v.c1 = c1; v.c2 = c2;
    v.ear = ear; v.ebr = ebr; v.eh1 = eh1; v.eh2 = eh2;
    v.ewe = ewe; v.edst = edst; v.eval = eval;
    v.epend = epend; v.ewaw = ewaw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    start    = v.st;
    a_valid  = v.av; a_dest = v.ad; a_data = v.adat;
    b_valid  = v.bv; b_dest = v.bd; b_data = v.bdat;
    rsv_en   = v.rv; rsv_dest = v.rd;
    chk_reg1 = v.c1; chk_reg2 = v.c2;
  endtask

  task automatic idle();
    start = 0; a_valid = 0; b_valid = 0; rsv_en = 0;
  endtask

  initial begin
    //          st av ad adat bv bd bdat rv rd c1 c2  ar br h1 h2 we dst val pend waw
    tv[0]  = mk(0, 0,0,8'h00, 0,0,8'h00, 0,0, 0,0,   0,0,0,0, 0,0,8'h00,16'h0000,0);
    tv[1]  = mk(0, 1,5,8'h3C, 0,0,8'h00, 0,0, 5,0,   1,0,0,0, 1,5,8'h3C,16'h0000,0);
    tv[2]  = mk(0, 0,0,8'h00, 0,0,8'h00, 0,0, 5,4,   0,0,1,0, 0,5,8'h3C,16'h0000,0);
    tv[3]  = mk(0, 1,1,8'h11, 1,2,8'h22, 0,0, 1,2,   1,0,0,0, 1,1,8'h11,16'h0000,0);
    tv[4]  = mk(0, 1,1,8'h11, 1,2,8'h22, 0,0, 1,2,   0,1,1,0, 1,2,8'h22,16'h0000,0);
    tv[5]  = mk(0, 1,1,8'h11, 1,2,8'h22, 0,0, 1,2,   1,0,0,1, 1,1,8'h11,16'h0000,0);
    tv[6]  = mk(0, 1,1,8'h11, 1,2,8'h22, 0,0, 1,2,   0,1,1,0, 1,2,8'h22,16'h0000,0);
    tv[7]  = mk(0, 0,0,8'h00, 0,0,8'h00, 0,0, 7,2,   0,0,0,1, 0,2,8'h22,16'h0000,0);
    tv[8]  = mk(0, 0,0,8'h00, 0,0,8'h00, 1,7, 7,0,   0,0,0,0, 0,2,8'h22,16'h0080,0);
    tv[9]  = mk(0, 0,0,8'h00, 0,0,8'h00, 0,0, 7,0,   0,0,1,0, 0,2,8'h22,16'h0080,0);
    tv[10] = mk(0, 0,0,8'h00, 1,7,8'h5A, 0,0, 7,0,   0,1,1,0, 1,7,8'h5A,16'h0000,0);
    tv[11] = mk(0, 0,0,8'h00, 0,0,8'h00, 0,0, 7,0,   0,0,1,0, 0,7,8'h5A,16'h0000,0);
    tv[12] = mk(0, 0,0,8'h00, 0,0,8'h00, 0,0, 7,0,   0,0,0,0, 0,7,8'h5A,16'h0000,0);
    tv[13] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,3, 3,0,   0,0,0,0, 0,7,8'h5A,16'h0008,0);
    tv[14] = mk(0, 1,3,8'h33, 0,0,8'h00, 1,3, 3,0,   1,0,1,0, 1,3,8'h33,16'h0008,1);
    tv[15] = mk(0, 0,0,8'h00, 1,3,8'h44, 0,0, 3,0,   0,1,1,0, 1,3,8'h44,16'h0000,1);
    tv[16] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,4, 0,0,   0,0,0,0, 0,3,8'h44,16'h0010,1);
    tv[17] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,5, 0,0,   0,0,0,0, 0,3,8'h44,16'h0030,1);
    tv[18] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,6, 0,0,   0,0,0,0, 0,3,8'h44,16'h0070,1);
    tv[19] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,7, 0,0,   0,0,0,0, 0,3,8'h44,16'h00F0,1);
    tv[20] = mk(0, 1,1,8'h01, 1,2,8'h02, 0,0, 4,1,   1,0,1,0, 1,1,8'h01,16'h00F0,1);
    tv[21] = mk(1, 1,9,8'h99, 1,10,8'hAA,1,0, 1,5,   0,0,1,1, 0,1,8'h01,16'h0000,0);
    tv[22] = mk(0, 1,1,8'h11, 1,2,8'h22, 0,0, 1,0,   1,0,0,0, 1,1,8'h11,16'h0000,0);

    reset = 0;
    idle();
    a_dest = 0; a_data = 0; b_dest = 0; b_data = 0;
    rsv_dest = 0; chk_reg1 = 0; chk_reg2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   32'(rf_write_en), 32'h0);
    chk("rst_dest", 32'(rf_reg_dest), 32'h0);
    chk("rst_val",  32'(rf_val_in),   32'h0);
    chk("rst_pend", 32'(pending),     32'h0);
    chk("rst_waw",  32'(waw_err),     32'h0);
    reset = 1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(tv[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(tv[i].ebr));
      chk($sformatf("v%0d_hazard1", i), 32'(hazard1), 32'(tv[i].eh1));
      chk($sformatf("v%0d_hazard2", i), 32'(hazard2), 32'(tv[i].eh2));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i),   32'(rf_write_en), 32'(tv[i].ewe));
      chk($sformatf("v%0d_dest", i), 32'(rf_reg_dest), 32'(tv[i].edst));
      chk($sformatf("v%0d_val", i),  32'(rf_val_in),   32'(tv[i].eval));
      chk($sformatf("v%0d_pend", i), 32'(pending),     32'(tv[i].epend));
      chk($sformatf("v%0d_waw", i),  32'(waw_err),     32'(tv[i].ewaw));
    end

    // Double reservation of r2 without an intervening write.
    idle();
    rsv_en = 1; rsv_dest = 2;
    @(posedge clk); #1;
    chk("dbl_rsv1_waw", 32'(waw_err), 32'h0);
    @(posedge clk); #1;
    chk("dbl_rsv2_pend", 32'(pending), 32'h0004);
    chk("dbl_rsv2_waw",  32'(waw_err), 32'h1);

    // Uncontested A write, then async reset while the write is live.
    idle();
    a_valid = 1; a_dest = 6; a_data = 8'h66;
    @(posedge clk); #1;
    idle();
    chk("pre_rst_we",  32'(rf_write_en), 32'h1);
    chk("pre_rst_val", 32'(rf_val_in),   32'h66);
    #2;
    reset = 0;
    #1;
    chk("arst_we",   32'(rf_write_en), 32'h0);
    chk("arst_dest", 32'(rf_reg_dest), 32'h0);
    chk("arst_val",  32'(rf_val_in),   32'h0);
    chk("arst_pend", 32'(pending),     32'h0);
    chk("arst_waw",  32'(waw_err),     32'h0);
    @(negedge clk);
    reset = 1;

    // Pointer was B before reset; contention must now go to A.
    a_valid = 1; a_dest = 1; a_data = 8'h11;
    b_valid = 1; b_dest = 2; b_data = 8'h22;
    #1;
    chk("post_rst_a_ready", 32'(a_ready), 32'h1);
    chk("post_rst_b_ready", 32'(b_ready), 32'h0);
    @(posedge clk); #1;
    idle();
    chk("post_rst_dest", 32'(rf_reg_dest), 32'h1);
    chk("post_rst_val",  32'(rf_val_in),   32'h11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Owns the single write port of the 16-entry register file.
- Arbitrates write-back requests between the ALU and the memory/load unit, and drives the register file's write_en, reg_dest and val_in from registered outputs.
- Keeps a per-register pending-write scoreboard so decode can stall reads whose source still has an outstanding writer.
- Sits between the execute/memory stages and the register file.

Parameters:
NUM_REGS, 16, number of architectural registers (matches the register file)
ADDR_W, 4, register index width
DATA_W, 8, register data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  synchronous clear; matches the register file's start semantics
a_valid  input  1  ALU write-back request
a_ready  output  1  ALU request accepted this cycle
a_dest  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
b_valid  input  1  load-unit write-back request
b_ready  output  1  load request accepted this cycle
b_dest  input  ADDR_W  load destination register
b_data  input  DATA_W  load data
rsv_en  input  1  issue stage reserves a destination
rsv_dest  input  ADDR_W  register being reserved
chk_reg1  input  ADDR_W  decode source operand 1
chk_reg2  input  ADDR_W  decode source operand 2
hazard1  output  1  operand 1 not safe to read
hazard2  output  1  operand 2 not safe to read
rf_write_en  output  1  to register file write_en
rf_reg_dest  output  ADDR_W  to register file reg_dest
rf_val_in  output  DATA_W  to register file val_in
pending  output  NUM_REGS  scoreboard bit per register
waw_err  output  1  sticky: reservation made on an already-pending register

Behaviour:
- Reset (reset low, asynchronous):
  - rf_write_en=0, rf_reg_dest=0, rf_val_in=0.
  - pending=0, waw_err=0.
  - Priority pointer = A.
- Handshake:
  - Transfer occurs when valid && ready.
  - a_ready and b_ready are combinational grants; at most one is high per cycle.
  - A requester holds valid, dest and data stable until its ready is seen.
  - ready is never asserted without the matching valid.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted, and the pointer moves to the loser at that edge.
  - Uncontested grants leave the pointer unchanged.
  - Round-robin on contention guarantees each side waits at most one contested cycle.
- Write output:
  - On the edge after a transfer, rf_write_en=1 for exactly one cycle, with rf_reg_dest/rf_val_in = the accepted dest/data.
  - Total latency is one cycle from transfer to write enable; the register file commits one edge later.
  - With no transfer, rf_write_en=0 and rf_reg_dest/rf_val_in hold their last values.
  - Back-to-back transfers give back-to-back write cycles; throughput is 1 write per cycle.
- Scoreboard:
  - A transfer to dest d clears pending[d] at the transfer edge.
  - rsv_en sets pending[rsv_dest] at the edge.
  - Same-edge set and clear of the same register: set wins.
  - rsv_en on an already-set bit leaves it set and sets waw_err (sticky until reset or start).
  - A transfer to a non-pending register is legal; the write proceeds and pending stays 0.
- Hazard (combinational):
  - hazardN = pending[chk_regN] OR (rf_write_en AND rf_reg_dest==chk_regN).
  - The second term is required because the register file registers its read outputs on the same edge that commits the write, so a same-cycle read returns the stale value.
  - Register 0 (rX) has no special casing.
- start high (synchronous, reset not asserted):
  - Next edge: pending=0, waw_err=0, pointer=A, rf_write_en=0.
  - a_ready=b_ready=0 during the start cycle; no transfer and no reservation take effect.
- Reset mid-operation: asserting reset immediately drops rf_write_en and the scoreboard; an in-flight accepted write is lost.

Test Plan:
- Reset then single ALU write: a_valid, a_dest=5, a_data=0x3C -> a_ready=1 same cycle; next cycle rf_write_en=1, rf_reg_dest=5, rf_val_in=0x3C; following cycle rf_write_en=0.
- Contention fairness: a_valid and b_valid held high for 4 cycles (a_dest=1/0x11, b_dest=2/0x22) -> grants A,B,A,B; rf outputs follow one cycle later.
- Scoreboard/hazard: rsv_en rsv_dest=7, then chk_reg1=7 -> hazard1=1; b transfer dest=7 -> pending[7] clears at that edge but hazard1 stays 1 while rf_write_en=1 with dest 7; drops to 0 the following cycle.
- Set/clear collision: rsv_en rsv_dest=3 on the same edge as an A transfer with dest 3 (pending[3] previously 1) -> pending[3] remains 1, waw_err=1.
- start mid-stream: pending=0x00F0, pointer=B, a_valid high, start pulsed -> a_ready=0 that cycle; next cycle pending=0, rf_write_en=0, waw_err=0, and an A-vs-B contest grants A.
- Async reset during rf_write_en=1 -> rf_write_en drops to 0 without a clock edge; all outputs read 0.
